hyperram_xfer_seq: RTL and testbench

- Transaction sequencer directly upstream of the four hyperram_intf_impl_wrap channel instances. Replaces the ad-hoc debug FSM in the top level.
- Accepts one burst request at a time over valid/ready: chip, read/write, address, word count, latency.
- Issues the one-cycle ctrl_cs strobe to the selected channel and drives the shared ctrl_* command buses.
- Write bursts: streams write data into the selected channel, one beat per accepted wr_data beat.
- Read bursts: collects read beats from the selected channel only, tags them with the chip index and counts them to completion, with a watchdog on stalled reads.

---
 rtl/hyperram_xfer_seq.sv | 180 ++++++++++++++++++
 tb/tb_hyperram_xfer_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_xfer_seq.sv
// Burst sequencer in front of the HyperRAM channel controllers: takes one request,
// strobes the chosen channel, then streams write beats or gathers read beats.
module hyperram_xfer_seq #(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_chip,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_num_words,
    input  logic [2:0]               req_latency,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [1:0]               rd_chip,
    input  logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
    input  logic [NUM_CH-1:0]        ch_rd_valid,
    output logic [NUM_CH-1:0]        ctrl_cs,
    output logic [1:0]               ctrl_mode,
    output logic [31:0]              ctrl_addr,
    output logic [31:0]              ctrl_num_words,
    output logic [2:0]               ctrl_latency,
    output logic [DATA_W-1:0]        ctrl_wr_data,
    output logic [NUM_CH-1:0]        ctrl_wr_data_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [1:0]        r_chip;
    logic              r_write;
    logic [31:0]       r_addr;
    logic [31:0]       r_num_words;
    logic [2:0]        r_latency;
    logic [1:0]        r_mode;
    logic [31:0]       r_count;
    logic [WD_W-1:0]   r_wdog;
    logic [DATA_W-1:0] r_wr_data;
    logic [NUM_CH-1:0] r_wr_data_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [1:0]        r_rd_chip;
    logic              r_err_timeout;

    logic              w_req_ready;
    logic              w_accept;
    logic [NUM_CH-1:0] w_chip_oh;
    logic              w_count_done;
    logic              w_wr_ready;
    logic              w_wr_beat;
    logic [DATA_W-1:0] w_sel_rd_data;
    logic              w_rd_hit;
    logic              w_wd_expire;

    // Handshakes: a transfer happens on any edge where valid and ready are both
    // high; ready never depends on the matching valid.
    assign w_req_ready   = (r_state == S_IDLE) && ch_ready[req_chip];
    assign w_accept      = req_valid && w_req_ready;
    assign w_chip_oh     = NUM_CH'(1) << r_chip;
    assign w_count_done  = (r_count == r_num_words);
    assign w_wr_ready    = (r_state == S_WRITE) && (r_count < r_num_words);
    assign w_wr_beat     = wr_valid && w_wr_ready;
    assign w_sel_rd_data = ch_rd_data[r_chip*DATA_W +: DATA_W];
    assign w_rd_hit      = (r_state == S_READ) && ch_rd_valid[r_chip] && !w_count_done;
    assign w_wd_expire   = (r_wdog == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_chip          <= '0;
            r_write         <= 1'b0;
            r_addr          <= '0;
            r_num_words     <= '0;
            r_latency       <= '0;
            r_mode          <= '0;
            r_count         <= '0;
            r_wdog          <= '0;
            r_wr_data       <= '0;
            r_wr_data_valid <= '0;
            r_rd_data       <= '0;
            r_rd_valid      <= 1'b0;
            r_rd_chip       <= '0;
            r_err_timeout   <= 1'b0;
        end else begin
            r_wr_data_valid <= w_wr_beat ? w_chip_oh : '0;
            if (w_wr_beat) begin
                r_wr_data <= wr_data;
            end
            r_rd_valid <= w_rd_hit;
            if (w_rd_hit) begin
                r_rd_data <= w_sel_rd_data;
                r_rd_chip <= r_chip;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_chip        <= req_chip;
                        r_write       <= req_write;
                        r_addr        <= req_addr;
                        r_num_words   <= req_num_words;
                        r_latency     <= req_latency;
                        r_mode        <= {1'b0, ~req_write};
                        r_count       <= '0;
                        r_err_timeout <= 1'b0;
                        r_state       <= (req_num_words == 32'd0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_count <= '0;
                    r_wdog  <= '0;
                    r_state <= r_write ? S_WRITE : S_READ;
                end
                S_WRITE: begin
                    if (w_count_done) begin
                        r_state <= S_DONE;
                    end else if (w_wr_beat) begin
                        r_count <= r_count + 32'd1;
                    end
                end
                S_READ: begin
                    // Completion wins over the watchdog; the watchdog only
                    // runs while beats are still owed.
                    if (w_count_done) begin
                        r_state <= S_DONE;
                    end else if (w_rd_hit) begin
                        r_count <= r_count + 32'd1;
                        r_wdog  <= '0;
                    end else if (w_wd_expire) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by rst so they drop in the reset cycle itself.
    assign ctrl_cs            = ((r_state == S_ISSUE) && !rst) ? w_chip_oh : '0;
    assign ctrl_wr_data_valid = rst ? '0 : r_wr_data_valid;
    assign req_ready          = w_req_ready;
    assign wr_ready           = w_wr_ready;
    assign ctrl_mode          = r_mode;
    assign ctrl_addr          = r_addr;
    assign ctrl_num_words     = r_num_words;
    assign ctrl_latency       = r_latency;
    assign ctrl_wr_data       = r_wr_data;
    assign rd_data            = r_rd_data;
    assign rd_valid           = r_rd_valid;
    assign rd_chip            = r_rd_chip;
    assign busy               = (r_state != S_IDLE);
    assign done               = (r_state == S_DONE);
    assign err_timeout        = r_err_timeout;

endmodule

// File: tb/tb_hyperram_xfer_seq.sv
// Directed bench for hyperram_xfer_seq: drivers push cycle-tagged expectations,
// a monitor thread pops and compares whenever the DUT presents an output.
module tb_hyperram_xfer_seq;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic                     req_write = 1'b0;
    logic [1:0]               req_chip = '0;
    logic [31:0]              req_addr = '0;
    logic [31:0]              req_num_words = '0;
    logic [2:0]               req_latency = '0;
    logic [DATA_W-1:0]        wr_data = '0;
    logic                     wr_valid = 1'b0;
    logic                     wr_ready;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic [1:0]               rd_chip;
    logic [NUM_CH-1:0]        ch_ready = '0;
    logic [NUM_CH*DATA_W-1:0] ch_rd_data = '0;
    logic [NUM_CH-1:0]        ch_rd_valid = '0;
    logic [NUM_CH-1:0]        ctrl_cs;
    logic [1:0]               ctrl_mode;
    logic [31:0]              ctrl_addr;
    logic [31:0]              ctrl_num_words;
    logic [2:0]               ctrl_latency;
    logic [DATA_W-1:0]        ctrl_wr_data;
    logic [NUM_CH-1:0]        ctrl_wr_data_valid;
    logic                     busy;
    logic                     done;
    logic                     err_timeout;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    logic [127:0] exp_wr_q[$];
    logic [127:0] exp_rd_q[$];
    logic [127:0] exp_cs_q[$];
    int           exp_done_q[$];

    hyperram_xfer_seq #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_chip(req_chip), .req_addr(req_addr), .req_num_words(req_num_words),
        .req_latency(req_latency),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_chip(rd_chip),
        .ch_ready(ch_ready), .ch_rd_data(ch_rd_data), .ch_rd_valid(ch_rd_valid),
        .ctrl_cs(ctrl_cs), .ctrl_mode(ctrl_mode), .ctrl_addr(ctrl_addr),
        .ctrl_num_words(ctrl_num_words), .ctrl_latency(ctrl_latency),
        .ctrl_wr_data(ctrl_wr_data), .ctrl_wr_data_valid(ctrl_wr_data_valid),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the queues
    task automatic monitor_loop();
        logic [127:0] act;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ctrl_wr_data_valid != '0) begin
                    if (exp_wr_q.size() == 0) chk("wr_unexpected", 128'(ctrl_wr_data_valid), 128'(0));
                    else begin
                        act = '0;
                        act[67:0] = {32'(cyc), ctrl_wr_data_valid, ctrl_wr_data};
                        chk("wr_beat", act, exp_wr_q.pop_front());
                    end
                end
                if (rd_valid) begin
                    if (exp_rd_q.size() == 0) chk("rd_unexpected", 128'(rd_valid), 128'(0));
                    else begin
                        act = '0;
                        act[65:0] = {32'(cyc), rd_chip, rd_data};
                        chk("rd_beat", act, exp_rd_q.pop_front());
                    end
                end
                if (ctrl_cs != '0) begin
                    if (exp_cs_q.size() == 0) chk("cs_unexpected", 128'(ctrl_cs), 128'(0));
                    else begin
                        act = '0;
                        act[104:0] = {32'(cyc), ctrl_cs, ctrl_addr, ctrl_num_words, ctrl_mode, ctrl_latency};
                        chk("cs_issue", act, exp_cs_q.pop_front());
                    end
                end
                if (done) begin
                    if (exp_done_q.size() == 0) chk("done_unexpected", 128'(done), 128'(0));
                    else chk("done_cycle", 128'(cyc), 128'(exp_done_q.pop_front()));
                end
            end
        end
    endtask

    // Driver tasks
    task automatic send_req(input logic wr, input logic [1:0] chip, input logic [31:0] addr,
                            input logic [31:0] nw, input logic [2:0] lat, output int acc);
        logic [127:0] e;
        req_write = wr; req_chip = chip; req_addr = addr; req_num_words = nw; req_latency = lat;
        req_valid = 1'b1;
        #1;
        for (int w = 0; w < 20 && !req_ready; w++) tick();
        if (!req_ready) begin
            chk("req_accept_timeout", 128'(req_ready), 128'(1));
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        tick();
        req_valid = 1'b0;
        acc = cyc;
        if (nw != 0) begin
            e = '0;
            e[104:0] = {32'(acc), 4'(4'b0001 << chip), addr, nw, {1'b0, ~wr}, lat};
            exp_cs_q.push_back(e);
        end else begin
            exp_done_q.push_back(acc);
        end
        chk("busy_after_accept", 128'(busy), 128'(1));
    endtask

    task automatic wr_stream(input logic [1:0] chip, input logic [31:0] base, input int n,
                             input int gap, input bit final_beat);
        logic [127:0] e;
        int last;
        last = cyc;
        for (int i = 0; i < n; i++) begin
            wr_data = base + 32'(i);
            wr_valid = 1'b1;
            for (int w = 0; w < 20 && !wr_ready; w++) tick();
            if (!wr_ready) begin
                chk("wr_ready_timeout", 128'(wr_ready), 128'(1));
                wr_valid = 1'b0;
                return;
            end
            e = '0;
            e[67:0] = {32'(cyc + 1), 4'(4'b0001 << chip), wr_data};
            exp_wr_q.push_back(e);
            last = cyc;
            tick();
            if (gap > 0) begin
                wr_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        wr_valid = 1'b0;
        if (final_beat) exp_done_q.push_back(last + 2);
    endtask

    // One cycle of per-channel read beats; channel k carries data ^ (k << 28).
    task automatic ch_beat(input logic [3:0] mask, input logic [1:0] chip, input logic [31:0] data,
                           input bit push);
        logic [127:0] e;
        ch_rd_valid = mask;
        for (int k = 0; k < NUM_CH; k++) ch_rd_data[k*DATA_W +: DATA_W] = data ^ (32'(k) << 28);
        if (push) begin
            e = '0;
            e[65:0] = {32'(cyc + 1), chip, data ^ (32'(chip) << 28)};
            exp_rd_q.push_back(e);
        end
        tick();
        ch_rd_valid = '0;
    endtask

    initial begin
        int acc;
        int lb;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) tick();
        chk("reset_ctrl_outputs", {ctrl_cs, ctrl_wr_data_valid, ctrl_mode, ctrl_addr, ctrl_num_words,
                                   ctrl_latency, ctrl_wr_data}, '0);
        chk("reset_status", {req_ready, wr_ready, rd_valid, rd_chip, rd_data, busy, done, err_timeout}, '0);
        rst = 1'b0;
        ch_ready = 4'hF;
        tick();
        chk("idle_req_ready", 128'(req_ready), 128'(1));

        // Write chip 2, N=4, back-to-back beats
        send_req(1'b1, 2'd2, 32'h100, 32'd4, 3'd3, acc);
        wr_stream(2'd2, 32'hA5A5_0001, 4, 0, 1'b1);
        repeat (3) tick();
        chk("wr_ready_idle", 128'(wr_ready), 128'(0));

        // Read chip 1, N=3, gaps and spurious chip 0 beats
        send_req(1'b0, 2'd1, 32'h2000, 32'd3, 3'd5, acc);
        ch_beat(4'b0010, 2'd1, 32'h0BAD_0000, 1'b0);   // ISSUE cycle: dropped
        ch_beat(4'b0001, 2'd0, 32'h0BAD_0001, 1'b0);   // wrong channel
        ch_beat(4'b0010, 2'd1, 32'h0000_1111, 1'b1);
        tick();
        ch_beat(4'b0011, 2'd1, 32'h0000_2222, 1'b1);
        tick();
        lb = cyc;
        ch_beat(4'b0010, 2'd1, 32'h0000_3333, 1'b1);
        exp_done_q.push_back(lb + 2);
        ch_beat(4'b0010, 2'd1, 32'h0BAD_0004, 1'b0);   // count already reached N
        ch_beat(4'b0010, 2'd1, 32'h0BAD_0005, 1'b0);   // DONE state
        repeat (2) tick();

        // Channel 3 not ready: request blocked until ch_ready[3] rises
        ch_ready = 4'b0111;
        req_write = 1'b1; req_chip = 2'd3; req_addr = 32'h300; req_num_words = 32'd1; req_latency = 3'd1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("req_ready_blocked", {req_ready, busy}, '0);
        end
        ch_ready = 4'hF;
        #1;
        chk("req_ready_released", 128'(req_ready), 128'(1));
        send_req(1'b1, 2'd3, 32'h300, 32'd1, 3'd1, acc);
        chk("blocked_accept_cycle", 128'(acc), 128'(cyc));
        wr_stream(2'd3, 32'h3333_0000, 1, 0, 1'b1);
        repeat (3) tick();

        // N = 0: straight to DONE, no strobe
        send_req(1'b0, 2'd0, 32'h0, 32'd0, 3'd2, acc);
        tick();
        chk("n0_busy_one_cycle", {busy, done}, '0);
        tick();

        // Read timeout: chip 3, N=8, only two beats
        send_req(1'b0, 2'd3, 32'h4000, 32'd8, 3'd7, acc);
        tick();
        ch_beat(4'b1000, 2'd3, 32'h0000_00A1, 1'b1);
        tick();
        lb = cyc;
        ch_beat(4'b1000, 2'd3, 32'h0000_00A2, 1'b1);
        for (int w = 0; w < 40 && !err_timeout; w++) tick();
        chk("err_timeout_set", 128'(err_timeout), 128'(1));
        chk("err_timeout_cycle", 128'(cyc), 128'(lb + 17));
        chk("timeout_idle", 128'(busy), 128'(0));
        repeat (3) tick();
        chk("err_timeout_sticky", 128'(err_timeout), 128'(1));
        send_req(1'b0, 2'd0, 32'h0, 32'd0, 3'd0, acc);
        chk("err_timeout_cleared", 128'(err_timeout), 128'(0));
        repeat (2) tick();

        // Reset mid-write after 2 of 5 beats
        send_req(1'b1, 2'd0, 32'h40, 32'd5, 3'd4, acc);
        wr_stream(2'd0, 32'hC0DE_0000, 2, 0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_wr_valid_low", 128'(ctrl_wr_data_valid), 128'(0));
        tick();
        rst = 1'b0;
        chk("rst_returns_idle", {busy, ctrl_wr_data_valid, wr_ready, done}, '0);
        tick();
        send_req(1'b1, 2'd0, 32'h80, 32'd3, 3'd6, acc);
        wr_stream(2'd0, 32'h5EED_0000, 3, 1, 1'b1);
        repeat (6) tick();

        chk("exp_wr_drained", 128'(exp_wr_q.size()), 128'(0));
        chk("exp_rd_drained", 128'(exp_rd_q.size()), 128'(0));
        chk("exp_cs_drained", 128'(exp_cs_q.size()), 128'(0));
        chk("exp_done_drained", 128'(exp_done_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
